// File: rtl/display_write_queue_pkg.sv
// rtl/display_write_queue_pkg.sv - shared display register widths, sprite indices and queue entry type
package display_write_queue_pkg;

  localparam int REG_INDEX_WIDTH = 7;
  localparam int REG_VALUE_WIDTH = 16;
  localparam int ENTRY_WIDTH     = REG_INDEX_WIDTH + REG_VALUE_WIDTH;

  // Each sprite owns four consecutive registers: sprite0 at 2..5, sprite1 at 6..9.
  localparam logic [REG_INDEX_WIDTH-1:0] SPRITE0_BASE = 7'd2;
  localparam logic [REG_INDEX_WIDTH-1:0] SPRITE1_BASE = 7'd6;
  localparam int                         SPRITE_REGS  = 4;

  typedef struct packed {
    logic [REG_INDEX_WIDTH-1:0] index;
    logic [REG_VALUE_WIDTH-1:0] value;
  } reg_write_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy counter and combinational read data
module sync_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // Pointers wrap naturally; full/empty come from the counter so a full queue is unambiguous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr];
  assign count_o = count;
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);

endmodule

// File: rtl/display_write_queue.sv
// rtl/display_write_queue.sv - holds CPU display register writes and releases them only during vblank
module display_write_queue
  import display_write_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_write_i,
  input  logic [REG_INDEX_WIDTH-1:0]  cpu_index_i,
  input  logic [REG_VALUE_WIDTH-1:0]  cpu_value_i,
  input  logic                        clear_overflow_i,
  input  logic                        in_vblank_i,
  output logic                        register_write_o,
  output logic [REG_INDEX_WIDTH-1:0]  register_index_o,
  output logic [REG_VALUE_WIDTH-1:0]  register_value_o,
  output logic                        full_o,
  output logic [$clog2(DEPTH):0]      pending_o,
  output logic                        overflow_o,
  output logic [15:0]                 frame_count_o
);

  reg_write_t push_entry;
  reg_write_t pop_entry;
  logic       fifo_full;
  logic       fifo_empty;
  logic       drain;
  logic       accept;
  logic       drop;
  logic       vblank_q;
  logic       armed_q;

  // A full queue still takes a write when a pop frees a slot on the same edge.
  assign drain      = in_vblank_i & ~fifo_empty;
  assign accept     = cpu_write_i & (~fifo_full | drain);
  assign drop       = cpu_write_i & ~accept;
  assign push_entry = '{index: cpu_index_i, value: cpu_value_i};
  assign full_o     = fifo_full;

  sync_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .pop     (drain),
    .data_i  (push_entry),
    .data_o  (pop_entry),
    .count_o (pending_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      register_write_o <= 1'b0;
      register_index_o <= '0;
      register_value_o <= '0;
      overflow_o       <= 1'b0;
      vblank_q         <= 1'b0;
      armed_q          <= 1'b0;
      frame_count_o    <= '0;
    end else begin
      register_write_o <= drain;
      if (drain) begin
        register_index_o <= pop_entry.index;
        register_value_o <= pop_entry.value;
      end
      if (drop) overflow_o <= 1'b1;
      else if (clear_overflow_i) overflow_o <= 1'b0;
      vblank_q <= in_vblank_i;
      armed_q  <= 1'b1;
      // The first clock after reset only primes vblank_q, so a vblank already in progress is not counted.
      if (armed_q && in_vblank_i && !vblank_q) frame_count_o <= frame_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_display_write_queue.sv
// tb/tb_display_write_queue.sv - directed self-checking bench for display_write_queue
module tb_display_write_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_write_i;
  logic [6:0]  cpu_index_i;
  logic [15:0] cpu_value_i;
  logic        clear_overflow_i;
  logic        in_vblank_i;
  logic        register_write_o;
  logic [6:0]  register_index_o;
  logic [15:0] register_value_o;
  logic        full_o;
  logic [4:0]  pending_o;
  logic        overflow_o;
  logic [15:0] frame_count_o;

  int passed = 0;
  int total  = 0;
  logic [22:0] exp_q [$];

  always #5 clk = ~clk;

  display_write_queue #(.DEPTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_write_i      (cpu_write_i),
    .cpu_index_i      (cpu_index_i),
    .cpu_value_i      (cpu_value_i),
    .clear_overflow_i (clear_overflow_i),
    .in_vblank_i      (in_vblank_i),
    .register_write_o (register_write_o),
    .register_index_o (register_index_o),
    .register_value_o (register_value_o),
    .full_o           (full_o),
    .pending_o        (pending_o),
    .overflow_o       (overflow_o),
    .frame_count_o    (frame_count_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_strobe(input string tag, input logic [6:0] idx, input logic [15:0] val);
    chk({tag, "_wr"}, {31'd0, register_write_o}, 32'd1);
    chk({tag, "_idx"}, {25'd0, register_index_o}, {25'd0, idx});
    chk({tag, "_val"}, {16'd0, register_value_o}, {16'd0, val});
  endtask

  task automatic cpu_wr(input logic [6:0] idx, input logic [15:0] val);
    cpu_write_i = 1'b1;
    cpu_index_i = idx;
    cpu_value_i = val;
    tick();
    cpu_write_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_write_i = 1'b0;
    cpu_index_i = '0;
    cpu_value_i = '0;
    clear_overflow_i = 1'b0;
    in_vblank_i = 1'b0;
    tick();
    tick();
    chk("rst_wr", {31'd0, register_write_o}, 32'd0);
    chk("rst_idx", {25'd0, register_index_o}, 32'd0);
    chk("rst_val", {16'd0, register_value_o}, 32'd0);
    chk("rst_pending", {27'd0, pending_o}, 32'd0);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
    chk("rst_frame", {16'd0, frame_count_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Deferred release: writes outside vblank wait for the next vblank.
    cpu_wr(7'd2, 16'd100);
    chk("defer_nowr0", {31'd0, register_write_o}, 32'd0);
    cpu_wr(7'd3, 16'd50);
    chk("defer_nowr1", {31'd0, register_write_o}, 32'd0);
    cpu_wr(7'd5, 16'd1);
    chk("defer_nowr2", {31'd0, register_write_o}, 32'd0);
    chk("defer_pending3", {27'd0, pending_o}, 32'd3);
    tick();
    chk("defer_nowr3", {31'd0, register_write_o}, 32'd0);
    in_vblank_i = 1'b1;
    tick();
    chk_strobe("defer_s0", 7'd2, 16'd100);
    chk("defer_frame1", {16'd0, frame_count_o}, 32'd1);
    tick();
    chk_strobe("defer_s1", 7'd3, 16'd50);
    tick();
    chk_strobe("defer_s2", 7'd5, 16'd1);
    chk("defer_pending0", {27'd0, pending_o}, 32'd0);
    tick();
    chk("defer_idle_wr", {31'd0, register_write_o}, 32'd0);
    chk("defer_hold_idx", {25'd0, register_index_o}, 32'd5);
    chk("defer_hold_val", {16'd0, register_value_o}, 32'd1);
    in_vblank_i = 1'b0;
    tick();

    // Overflow, clear, set-beats-clear, and write accepted alongside a pop while full.
    for (int k = 0; k < 16; k++) cpu_wr(7'(k), 16'h1000 + 16'(k));
    chk("ovf_full", {31'd0, full_o}, 32'd1);
    chk("ovf_pending16", {27'd0, pending_o}, 32'd16);
    chk("ovf_before", {31'd0, overflow_o}, 32'd0);
    cpu_wr(7'h40, 16'hDEAD);
    chk("ovf_set", {31'd0, overflow_o}, 32'd1);
    chk("ovf_pending_after_drop", {27'd0, pending_o}, 32'd16);
    clear_overflow_i = 1'b1;
    tick();
    clear_overflow_i = 1'b0;
    chk("ovf_clear", {31'd0, overflow_o}, 32'd0);
    clear_overflow_i = 1'b1;
    cpu_wr(7'h41, 16'hDEAD);
    clear_overflow_i = 1'b0;
    chk("ovf_set_wins", {31'd0, overflow_o}, 32'd1);
    in_vblank_i = 1'b1;
    cpu_wr(7'h7F, 16'hBEEF);
    chk_strobe("full_pop0", 7'd0, 16'h1000);
    chk("full_push_pop_pending", {27'd0, pending_o}, 32'd16);
    chk("full_push_pop_ovf", {31'd0, overflow_o}, 32'd1);
    chk("ovf_frame2", {16'd0, frame_count_o}, 32'd2);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk_strobe("full_pop", 7'(k), 16'h1000 + 16'(k));
    end
    tick();
    chk_strobe("full_pop_last", 7'h7F, 16'hBEEF);
    chk("full_drained", {27'd0, pending_o}, 32'd0);
    chk("long_vblank_frame", {16'd0, frame_count_o}, 32'd2);
    in_vblank_i = 1'b0;
    clear_overflow_i = 1'b1;
    tick();
    clear_overflow_i = 1'b0;
    chk("ovf_clear2", {31'd0, overflow_o}, 32'd0);
    chk("full_idle_wr", {31'd0, register_write_o}, 32'd0);

    // Vblank ends after four pops; the remaining six go out next vblank.
    for (int k = 0; k < 10; k++) cpu_wr(7'd10 + 7'(k), 16'd200 + 16'(k));
    in_vblank_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_strobe("mid_a", 7'd10 + 7'(k), 16'd200 + 16'(k));
    end
    in_vblank_i = 1'b0;
    tick();
    chk("mid_stop_wr", {31'd0, register_write_o}, 32'd0);
    chk("mid_pending6", {27'd0, pending_o}, 32'd6);
    tick();
    in_vblank_i = 1'b1;
    for (int k = 4; k < 10; k++) begin
      tick();
      chk_strobe("mid_b", 7'd10 + 7'(k), 16'd200 + 16'(k));
    end
    tick();
    chk("mid_done_wr", {31'd0, register_write_o}, 32'd0);
    chk("mid_done_pending", {27'd0, pending_o}, 32'd0);
    chk("mid_frame4", {16'd0, frame_count_o}, 32'd4);
    in_vblank_i = 1'b0;
    tick();

    // Frame counter wrap from a preset value.
    force dut.frame_count_o = 16'hFFFF;
    tick();
    release dut.frame_count_o;
    tick();
    chk("wrap_preset", {16'd0, frame_count_o}, 32'h0000FFFF);
    in_vblank_i = 1'b1;
    tick();
    chk("wrap_zero", {16'd0, frame_count_o}, 32'd0);
    tick();
    tick();
    tick();
    chk("wrap_long_pulse", {16'd0, frame_count_o}, 32'd0);
    in_vblank_i = 1'b0;
    tick();

    // Forty writes drained in rounds so both pointers cross the wrap.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 8; k++) begin
        cpu_wr(7'(r * 8 + k + 20), 16'h5000 + 16'(r * 8 + k));
        exp_q.push_back({7'(r * 8 + k + 20), 16'h5000 + 16'(r * 8 + k)});
      end
      in_vblank_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
        logic [22:0] e;
        tick();
        e = exp_q.pop_front();
        chk_strobe("ptr_wrap", e[22:16], e[15:0]);
      end
      in_vblank_i = 1'b0;
      tick();
      chk("ptr_wrap_empty", {27'd0, pending_o}, 32'd0);
    end
    chk("ptr_wrap_frame", {16'd0, frame_count_o}, 32'd5);

    // Reset during vblank with five pending entries.
    for (int k = 0; k < 5; k++) cpu_wr(7'd60 + 7'(k), 16'd7 + 16'(k));
    chk("rstmid_pending5", {27'd0, pending_o}, 32'd5);
    in_vblank_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_pending0", {27'd0, pending_o}, 32'd0);
    chk("rstmid_wr0", {31'd0, register_write_o}, 32'd0);
    chk("rstmid_frame0", {16'd0, frame_count_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid_release_frame", {16'd0, frame_count_o}, 32'd0);
    chk("rstmid_release_wr", {31'd0, register_write_o}, 32'd0);
    tick();
    tick();
    chk("rstmid_no_strobe", {31'd0, register_write_o}, 32'd0);
    chk("rstmid_frame_still0", {16'd0, frame_count_o}, 32'd0);
    chk("rstmid_pending_still0", {27'd0, pending_o}, 32'd0);
    in_vblank_i = 1'b0;
    tick();
    in_vblank_i = 1'b1;
    tick();
    chk("rstmid_next_frame", {16'd0, frame_count_o}, 32'd1);
    in_vblank_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
